// File: rtl/sram_bus_pkg.sv
// ============================================================================
// sram_bus_pkg: shared encodings for the SRAM pin-bus master (rev 1.0)
// ============================================================================
`default_nettype none

package sram_bus_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_STROBE = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  localparam logic PIN_ACTIVE   = 1'b0;
  localparam logic PIN_INACTIVE = 1'b1;

  localparam int UB_BIT = 1;
  localparam int LB_BIT = 0;

  // Counter preload for a phase of 'count' cycles; 0 and 1 both give a one-cycle phase.
  function automatic logic [2:0] phase_load(input int count);
    if (count <= 1) return 3'd0;
    else            return 3'(count - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sram_phase_counter.sv
// ============================================================================
// sram_phase_counter: 3-bit loadable down-counter with zero flag (rev 1.0)
// ============================================================================
`default_nettype none

module sram_phase_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [2:0] load_val,
  output logic       zero
);

  logic [2:0] cnt_q;
  logic [2:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)                cnt_d = load_val;
    else if (cnt_q != 3'd0)  cnt_d = cnt_q - 3'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= 3'd0;
    else       cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == 3'd0);

endmodule

`default_nettype wire

// File: rtl/sram_bus_master.sv
// ============================================================================
// sram_bus_master: valid/ready requests to timed active-low SRAM pin cycles (rev 1.0)
// ============================================================================
`default_nettype none

module sram_bus_master
  import sram_bus_pkg::*;
#(
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 16,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_be,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              RAMCS,
  output logic              RAMOE,
  output logic              RAMWE,
  output logic              RAMLB,
  output logic              RAMUB,
  output logic [ADDR_W-1:0] ADR,
  output logic [DATA_W-1:0] sram_pins_dout,
  input  logic [DATA_W-1:0] sram_pins_din,
  output logic              sram_pins_drive
);

  localparam logic [2:0] SETUP_LD  = phase_load(SETUP_CYC);
  localparam logic [2:0] STROBE_LD = phase_load(STROBE_CYC);
  localparam logic [2:0] HOLD_LD   = phase_load(HOLD_CYC);

  logic [1:0]        state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        be_q, be_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ramcs_q, ramcs_d, ramoe_q, ramoe_d, ramwe_q, ramwe_d;
  logic              ramlb_q, ramlb_d, ramub_q, ramub_d;
  logic              drive_q, drive_d, rsp_valid_q, rsp_valid_d;
  logic              accept, active, load, zero;
  logic [2:0]        load_val;

  sram_phase_counter u_phase_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .zero     (zero)
  );

  assign req_ready = (state_q == ST_IDLE) && !reset;
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = (SETUP_CYC > 0) ? ST_SETUP : ST_STROBE;
      ST_SETUP:  if (zero)   state_d = ST_STROBE;
      ST_STROBE: if (zero)   state_d = (HOLD_CYC > 0) ? ST_HOLD : ST_IDLE;
      ST_HOLD:   if (zero)   state_d = ST_IDLE;
      default:               state_d = ST_IDLE;
    endcase

    load = (state_d != state_q) && (state_d != ST_IDLE);
    case (state_d)
      ST_SETUP:  load_val = SETUP_LD;
      ST_STROBE: load_val = STROBE_LD;
      ST_HOLD:   load_val = HOLD_LD;
      default:   load_val = 3'd0;
    endcase

    // Reads with no lanes selected still fetch the full word.
    we_d   = accept ? req_we : we_q;
    be_d   = accept ? ((req_we || (req_be != 2'b00)) ? req_be : 2'b11) : be_q;
    adr_d  = accept ? req_addr : adr_q;
    dout_d = (accept && req_we) ? req_wdata : dout_q;

    // Pins are registered from the next-state view so each phase's levels appear on entry.
    active   = (state_d != ST_IDLE);
    ramcs_d  = active ? PIN_ACTIVE : PIN_INACTIVE;
    ramoe_d  = ((state_d == ST_STROBE) && !we_d) ? PIN_ACTIVE : PIN_INACTIVE;
    ramwe_d  = ((state_d == ST_STROBE) && we_d && (be_d != 2'b00)) ? PIN_ACTIVE : PIN_INACTIVE;
    ramlb_d  = (active && be_d[LB_BIT]) ? PIN_ACTIVE : PIN_INACTIVE;
    ramub_d  = (active && be_d[UB_BIT]) ? PIN_ACTIVE : PIN_INACTIVE;
    drive_d  = active && we_d;

    rsp_valid_d = (state_q != ST_IDLE) && (state_d == ST_IDLE);
    rdata_d     = ((state_q == ST_STROBE) && zero && !we_q) ? sram_pins_din : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      be_q        <= 2'b00;
      adr_q       <= '0;
      dout_q      <= '0;
      rdata_q     <= '0;
      ramcs_q     <= PIN_INACTIVE;
      ramoe_q     <= PIN_INACTIVE;
      ramwe_q     <= PIN_INACTIVE;
      ramlb_q     <= PIN_INACTIVE;
      ramub_q     <= PIN_INACTIVE;
      drive_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      be_q        <= be_d;
      adr_q       <= adr_d;
      dout_q      <= dout_d;
      rdata_q     <= rdata_d;
      ramcs_q     <= ramcs_d;
      ramoe_q     <= ramoe_d;
      ramwe_q     <= ramwe_d;
      ramlb_q     <= ramlb_d;
      ramub_q     <= ramub_d;
      drive_q     <= drive_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign RAMCS           = ramcs_q;
  assign RAMOE           = ramoe_q;
  assign RAMWE           = ramwe_q;
  assign RAMLB           = ramlb_q;
  assign RAMUB           = ramub_q;
  assign ADR             = adr_q;
  assign sram_pins_dout  = dout_q;
  assign sram_pins_drive = drive_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_rdata       = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_sram_bus_master.sv
// ============================================================================
// tb_sram_bus_master: directed checks of the SRAM pin-bus master (rev 1.0)
// ============================================================================
`default_nettype none

module tb_sram_bus_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, req_valid, req_we, req_valid2, req_we2;
  logic [17:0] req_addr, req_addr2, adr, adr2;
  logic [1:0]  req_be, req_be2;
  logic [15:0] req_wdata, req_wdata2, rsp_rdata, rsp_rdata2, dout, dout2, din, din2;
  logic        req_ready, rsp_valid, ramcs, ramoe, ramwe, ramlb, ramub, drive;
  logic        req_ready2, rsp_valid2, ramcs2, ramoe2, ramwe2, ramlb2, ramub2, drive2;

  sram_bus_master u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .RAMCS(ramcs), .RAMOE(ramoe), .RAMWE(ramwe), .RAMLB(ramlb),
    .RAMUB(ramub), .ADR(adr), .sram_pins_dout(dout), .sram_pins_din(din), .sram_pins_drive(drive)
  );

  sram_bus_master #(.SETUP_CYC(0), .HOLD_CYC(0)) u_dut_fast (
    .clk(clk), .reset(reset), .req_valid(req_valid2), .req_ready(req_ready2), .req_we(req_we2),
    .req_addr(req_addr2), .req_be(req_be2), .req_wdata(req_wdata2), .rsp_valid(rsp_valid2),
    .rsp_rdata(rsp_rdata2), .RAMCS(ramcs2), .RAMOE(ramoe2), .RAMWE(ramwe2), .RAMLB(ramlb2),
    .RAMUB(ramub2), .ADR(adr2), .sram_pins_dout(dout2), .sram_pins_din(din2), .sram_pins_drive(drive2)
  );

  // Board memory map: block-RAM pad at 0x08000-0x081FF, everything else reads 0.
  logic [15:0] mem [0:511];
  initial for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
  assign din  = (!ramcs  && !ramoe  && adr[17:9]  == 9'h040) ? mem[adr[8:0]]  : 16'h0000;
  assign din2 = (!ramcs2 && !ramoe2 && adr2[17:9] == 9'h040) ? mem[adr2[8:0]] : 16'h0000;
  always @(posedge clk) begin
    if (!ramcs && !ramwe && adr[17:9] == 9'h040) begin
      if (!ramlb) mem[adr[8:0]][7:0]  <= dout[7:0];
      if (!ramub) mem[adr[8:0]][15:8] <= dout[15:8];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int m_cs = 0, m_we = 0, m_oe = 0, m_both = 0, m_ub = 0, m_lb = 0, m_drv = 0;
  int acc_n = 0, rsp_n = 0, acc2_n = 0, rsp2_n = 0, m_cs2 = 0;
  int acc_cyc [0:63];
  int rsp_cyc [0:63];
  int acc2_cyc [0:63];
  int rsp2_cyc [0:63];
  always @(negedge clk) begin
    if (!ramcs) m_cs++;
    if (!ramwe) m_we++;
    if (!ramoe) m_oe++;
    if (!ramoe && !ramwe) m_both++;
    if (!ramub) m_ub++;
    if (!ramlb) m_lb++;
    if (drive) m_drv++;
    if (!ramcs2) m_cs2++;
    if (req_valid && req_ready) begin if (acc_n < 64) acc_cyc[acc_n] = cyc; acc_n++; end
    if (rsp_valid) begin if (rsp_n < 64) rsp_cyc[rsp_n] = cyc; rsp_n++; end
    if (req_valid2 && req_ready2) begin if (acc2_n < 64) acc2_cyc[acc2_n] = cyc; acc2_n++; end
    if (rsp_valid2) begin if (rsp2_n < 64) rsp2_cyc[rsp2_n] = cyc; rsp2_n++; end
  end

  int n_cmp = 0, n_bad = 0;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic we, input logic [17:0] a, input logic [1:0] be, input logic [15:0] wd);
    req_we = we; req_addr = a; req_be = be; req_wdata = wd; req_valid = 1'b1;
    for (int n = 0; n < 20 && !req_ready; n++) tick();
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string name);
    int n;
    logic got;
    n = 0; got = 1'b0;
    while (!got && n < 30) begin
      @(negedge clk);
      got = rsp_valid;
      n++;
    end
    n_cmp++;
    if (!got) begin n_bad++; $display("FAIL %s_rsp_timeout: no rsp_valid within %0d cycles", name, n); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    n_cmp++; if ({ramcs, ramoe, ramwe, ramlb, ramub} !== 5'h1F) begin n_bad++; $display("FAIL reset_strobes: got %b want 11111", {ramcs, ramoe, ramwe, ramlb, ramub}); end
    n_cmp++; if ({adr, dout, drive} !== 35'h0) begin n_bad++; $display("FAIL reset_adr_dout_drive: got %h want 0", {adr, dout, drive}); end
    n_cmp++; if ({rsp_valid, rsp_rdata} !== 17'h0) begin n_bad++; $display("FAIL reset_rsp: got %h want 0", {rsp_valid, rsp_rdata}); end
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready_low: got %b want 0", req_ready); end
    reset = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready_high: got %b want 1", req_ready); end
  endtask

  task automatic test_write_read();
    int c0, w0, o0, d0;
    c0 = m_cs; w0 = m_we; o0 = m_oe; d0 = m_drv;
    issue(1'b1, 18'h08010, 2'b11, 16'hA55A);
    wait_rsp("wr_full");
    n_cmp++; if (m_cs - c0 !== 4) begin n_bad++; $display("FAIL wr_cs_cycles: got %0d want 4", m_cs - c0); end
    n_cmp++; if (m_we - w0 !== 2) begin n_bad++; $display("FAIL wr_we_cycles: got %0d want 2", m_we - w0); end
    n_cmp++; if (m_drv - d0 !== 4) begin n_bad++; $display("FAIL wr_drive_cycles: got %0d want 4", m_drv - d0); end
    n_cmp++; if (m_oe - o0 !== 0) begin n_bad++; $display("FAIL wr_oe_cycles: got %0d want 0", m_oe - o0); end
    tick();
    c0 = m_cs; w0 = m_we; o0 = m_oe; d0 = m_drv;
    issue(1'b0, 18'h08010, 2'b11, 16'h0000);
    wait_rsp("rd_full");
    n_cmp++; if (rsp_rdata !== 16'hA55A) begin n_bad++; $display("FAIL rd_full_data: got %h want a55a", rsp_rdata); end
    n_cmp++; if (m_cs - c0 !== 4) begin n_bad++; $display("FAIL rd_cs_cycles: got %0d want 4", m_cs - c0); end
    n_cmp++; if (m_oe - o0 !== 2 || m_we - w0 !== 0 || m_drv - d0 !== 0) begin n_bad++; $display("FAIL rd_oe_we_drive: got oe=%0d we=%0d drv=%0d want 2/0/0", m_oe - o0, m_we - w0, m_drv - d0); end
    tick();
  endtask

  task automatic test_byte_enable();
    int u0, l0;
    u0 = m_ub; l0 = m_lb;
    issue(1'b1, 18'h08010, 2'b01, 16'h1234);
    wait_rsp("wr_lb");
    n_cmp++; if (m_ub - u0 !== 0) begin n_bad++; $display("FAIL lb_write_ub: got %0d ub-low cycles want 0", m_ub - u0); end
    n_cmp++; if (m_lb - l0 !== 4) begin n_bad++; $display("FAIL lb_write_lb: got %0d lb-low cycles want 4", m_lb - l0); end
    tick();
    issue(1'b0, 18'h08010, 2'b11, 16'h0000);
    wait_rsp("rd_lb");
    n_cmp++; if (rsp_rdata !== 16'hA534) begin n_bad++; $display("FAIL lb_readback: got %h want a534", rsp_rdata); end
    tick();
  endtask

  task automatic test_back_to_back();
    int a0, r0, b0, n;
    a0 = acc_n; r0 = rsp_n; b0 = m_both; n = 0;
    req_we = 1'b0; req_addr = 18'h08010; req_be = 2'b11; req_valid = 1'b1;
    while (acc_n - a0 < 3 && n < 60) begin tick(); n++; end
    req_valid = 1'b0;
    n = 0;
    while (rsp_n - r0 < 3 && n < 60) begin tick(); n++; end
    n_cmp++;
    if (acc_n - a0 !== 3 || rsp_n - r0 !== 3) begin
      n_bad++; $display("FAIL b2b_counts: got acc=%0d rsp=%0d want 3/3", acc_n - a0, rsp_n - r0);
    end else begin
      for (int i = 1; i < 3; i++) begin
        n_cmp++; if (acc_cyc[a0+i] - acc_cyc[a0] !== 5 * i) begin n_bad++; $display("FAIL b2b_accept%0d: got +%0d want +%0d", i, acc_cyc[a0+i] - acc_cyc[a0], 5 * i); end
      end
      for (int i = 0; i < 3; i++) begin
        n_cmp++; if (rsp_cyc[r0+i] - acc_cyc[a0] !== 5 * (i + 1)) begin n_bad++; $display("FAIL b2b_rsp%0d: got +%0d want +%0d", i, rsp_cyc[r0+i] - acc_cyc[a0], 5 * (i + 1)); end
      end
    end
    n_cmp++; if (m_both - b0 !== 0) begin n_bad++; $display("FAIL b2b_oe_we_overlap: got %0d want 0", m_both - b0); end
    n_cmp++; if (rsp_rdata !== 16'hA534) begin n_bad++; $display("FAIL b2b_data: got %h want a534", rsp_rdata); end
    tick();
  endtask

  task automatic test_reset_abort();
    int r0;
    r0 = rsp_n;
    issue(1'b1, 18'h08030, 2'b11, 16'hBEEF);
    tick();
    n_cmp++; if (ramwe !== 1'b0) begin n_bad++; $display("FAIL abort_in_strobe: got RAMWE=%b want 0", ramwe); end
    reset = 1'b1;
    tick();
    n_cmp++; if ({ramwe, ramcs, drive} !== 3'b110) begin n_bad++; $display("FAIL abort_pins: got we/cs/drv=%b want 110", {ramwe, ramcs, drive}); end
    n_cmp++; if (rsp_rdata !== 16'h0000) begin n_bad++; $display("FAIL abort_rdata_clear: got %h want 0000", rsp_rdata); end
    reset = 1'b0;
    tick();
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL abort_ready: got %b want 1", req_ready); end
    repeat (8) tick();
    n_cmp++; if (rsp_n - r0 !== 0) begin n_bad++; $display("FAIL abort_no_rsp: got %0d pulses want 0", rsp_n - r0); end
  endtask

  task automatic test_zero_be_write();
    int w0, r0;
    w0 = m_we; r0 = rsp_n;
    issue(1'b1, 18'h08010, 2'b00, 16'hFFFF);
    wait_rsp("wr_be0");
    repeat (4) tick();
    n_cmp++; if (m_we - w0 !== 0) begin n_bad++; $display("FAIL be0_we_low: got %0d cycles want 0", m_we - w0); end
    n_cmp++; if (rsp_n - r0 !== 1) begin n_bad++; $display("FAIL be0_rsp_once: got %0d pulses want 1", rsp_n - r0); end
    issue(1'b0, 18'h08010, 2'b00, 16'h0000);
    wait_rsp("rd_be0");
    n_cmp++; if (rsp_rdata !== 16'hA534) begin n_bad++; $display("FAIL be0_readback: got %h want a534", rsp_rdata); end
    tick();
  endtask

  task automatic test_fast_timing();
    int a0, r0, c0, n;
    a0 = acc2_n; r0 = rsp2_n; n = 0;
    req_we2 = 1'b0; req_addr2 = 18'h08010; req_be2 = 2'b11; req_valid2 = 1'b1;
    while (acc2_n - a0 < 1 && n < 20) begin tick(); n++; end
    req_valid2 = 1'b0; n = 0;
    while (rsp2_n - r0 < 1 && n < 20) begin tick(); n++; end
    n_cmp++; if (rsp_rdata2 !== 16'hA534) begin n_bad++; $display("FAIL fast_mapped_read: got %h want a534", rsp_rdata2); end
    a0 = acc2_n; r0 = rsp2_n; c0 = m_cs2; n = 0;
    req_addr2 = 18'h3F000; req_valid2 = 1'b1;
    while (acc2_n - a0 < 3 && n < 40) begin tick(); n++; end
    req_valid2 = 1'b0; n = 0;
    while (rsp2_n - r0 < 3 && n < 40) begin tick(); n++; end
    n_cmp++; if (rsp_rdata2 !== 16'h0000) begin n_bad++; $display("FAIL fast_unmapped_read: got %h want 0000", rsp_rdata2); end
    n_cmp++; if (m_cs2 - c0 !== 6) begin n_bad++; $display("FAIL fast_cs_cycles: got %0d want 6", m_cs2 - c0); end
    n_cmp++;
    if (acc2_n - a0 !== 3 || rsp2_n - r0 !== 3) begin
      n_bad++; $display("FAIL fast_counts: got acc=%0d rsp=%0d want 3/3", acc2_n - a0, rsp2_n - r0);
    end else if (acc2_cyc[a0+1] - acc2_cyc[a0] !== 3 || acc2_cyc[a0+2] - acc2_cyc[a0] !== 6 ||
                 rsp2_cyc[r0] - acc2_cyc[a0] !== 3) begin
      n_bad++; $display("FAIL fast_period: got +%0d/+%0d rsp +%0d want +3/+6 rsp +3",
                        acc2_cyc[a0+1] - acc2_cyc[a0], acc2_cyc[a0+2] - acc2_cyc[a0], rsp2_cyc[r0] - acc2_cyc[a0]);
    end
    tick();
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_be = 2'b00; req_wdata = '0;
    req_valid2 = 1'b0; req_we2 = 1'b0; req_addr2 = '0; req_be2 = 2'b00; req_wdata2 = '0;
    test_reset();
    test_write_read();
    test_byte_enable();
    test_back_to_back();
    test_reset_abort();
    test_zero_be_write();
    test_fast_timing();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule

`default_nettype wire
